// File: rtl/ramcard_mem_arbiter.sv
// Two-port SRAM arbiter for the language/Saturn card (CPU path + DMA loader).
// Define RAMCARD_ARB_RR_EN for round-robin arbitration instead of fixed CPU priority.
module ramcard_mem_arbiter #(
   parameter int ADDR_W      = 18,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset_in,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_din,
   output logic [DATA_W-1:0] cpu_dout,
   output logic              cpu_ack,
   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_din,
   output logic [DATA_W-1:0] dma_dout,
   output logic              dma_ack,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              mem_ce_n,
   output logic              mem_oe_n,
   output logic              mem_we_n,
   output logic              busy
);

   if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait_cycles
      $error("ramcard_mem_arbiter: WAIT_CYCLES must be within 1..15");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_DONE
   } state_t;

   localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              gnt_dma_q, gnt_dma_d;
   logic              ce_n_q, ce_n_d;
   logic              oe_n_q, oe_n_d;
   logic              we_n_q, we_n_d;
   logic              busy_q, busy_d;
   logic              cpu_ack_q, cpu_ack_d;
   logic              dma_ack_q, dma_ack_d;
   logic [DATA_W-1:0] cpu_dout_q, cpu_dout_d;
   logic [DATA_W-1:0] dma_dout_q, dma_dout_d;
   logic              pick_dma;

`ifdef RAMCARD_ARB_RR_EN
   // prio_dma_q names the port that wins the next tie; it flips to the other port on every grant.
   logic prio_dma_q, prio_dma_d;

   assign pick_dma = dma_req && (!cpu_req || prio_dma_q);

   always_comb begin
      prio_dma_d = prio_dma_q;
      if (state_q == S_IDLE && (cpu_req || dma_req)) begin
         prio_dma_d = !pick_dma;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         prio_dma_q <= 1'b0;
      end else begin
         prio_dma_q <= prio_dma_d;
      end
   end
`else
   assign pick_dma = dma_req && !cpu_req;
`endif

   // Next-state logic; the SRAM strobes are derived from the next state so every pin comes straight off a flop.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      we_d       = we_q;
      gnt_dma_d  = gnt_dma_q;
      cpu_ack_d  = 1'b0;
      dma_ack_d  = 1'b0;
      cpu_dout_d = cpu_dout_q;
      dma_dout_d = dma_dout_q;

      case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               gnt_dma_d = pick_dma;
               addr_d    = pick_dma ? dma_addr : cpu_addr;
               wdata_d   = pick_dma ? dma_din  : cpu_din;
               we_d      = pick_dma ? dma_we   : cpu_we;
               state_d   = S_SETUP;
            end
         end
         S_SETUP: begin
            cnt_d   = CNT_LOAD;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (cnt_q == 4'd0) begin
               state_d = S_DONE;
               if (gnt_dma_q) begin
                  dma_ack_d = 1'b1;
                  if (!we_q) dma_dout_d = mem_rdata;
               end else begin
                  cpu_ack_d = 1'b1;
                  if (!we_q) cpu_dout_d = mem_rdata;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      ce_n_d = (state_d == S_IDLE);
      oe_n_d = !(((state_d == S_SETUP) || (state_d == S_STROBE)) && !we_d);
      we_n_d = !((state_d == S_STROBE) && we_d);
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         gnt_dma_q  <= 1'b0;
         ce_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         busy_q     <= 1'b0;
         cpu_ack_q  <= 1'b0;
         dma_ack_q  <= 1'b0;
         cpu_dout_q <= '0;
         dma_dout_q <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         we_q       <= we_d;
         gnt_dma_q  <= gnt_dma_d;
         ce_n_q     <= ce_n_d;
         oe_n_q     <= oe_n_d;
         we_n_q     <= we_n_d;
         busy_q     <= busy_d;
         cpu_ack_q  <= cpu_ack_d;
         dma_ack_q  <= dma_ack_d;
         cpu_dout_q <= cpu_dout_d;
         dma_dout_q <= dma_dout_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_ce_n  = ce_n_q;
   assign mem_oe_n  = oe_n_q;
   assign mem_we_n  = we_n_q;
   assign busy      = busy_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_dout  = cpu_dout_q;
   assign dma_dout  = dma_dout_q;

endmodule

// File: tb/tb_ramcard_mem_arbiter.sv
// Directed bench for ramcard_mem_arbiter: default build plus a WAIT_CYCLES=5 instance.
module tb_ramcard_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        cpuReq, cpuWe, dmaReq, dmaWe;
   logic [17:0] cpuAddr, dmaAddr, memAddr;
   logic [7:0]  cpuDin, cpuDout, dmaDin, dmaDout, memWdata, memRdata;
   logic        cpuAck, dmaAck, memCeN, memOeN, memWeN, busy;

   logic        fiveReq, fiveWe, fiveDmaAck, fiveCpuAck, fiveCeN, fiveOeN, fiveWeN, fiveBusy;
   logic [17:0] fiveAddr, fiveMemAddr;
   logic [7:0]  fiveDin, fiveDout, fiveDmaDout, fiveMemWdata, fiveRdata;

   int total = 0;
   int bad = 0;
   int cyc, weLow, oeLow, cpuAcks, dmaAcks, oeLow5, ackCyc;

   always #5 clk = ~clk;

   ramcard_mem_arbiter u_dut (
      .clk(clk), .reset_in(reset_in),
      .cpu_req(cpuReq), .cpu_we(cpuWe), .cpu_addr(cpuAddr), .cpu_din(cpuDin),
      .cpu_dout(cpuDout), .cpu_ack(cpuAck),
      .dma_req(dmaReq), .dma_we(dmaWe), .dma_addr(dmaAddr), .dma_din(dmaDin),
      .dma_dout(dmaDout), .dma_ack(dmaAck),
      .mem_addr(memAddr), .mem_wdata(memWdata), .mem_rdata(memRdata),
      .mem_ce_n(memCeN), .mem_oe_n(memOeN), .mem_we_n(memWeN), .busy(busy)
   );

   ramcard_mem_arbiter #(.WAIT_CYCLES(5)) u_dut5 (
      .clk(clk), .reset_in(reset_in),
      .cpu_req(fiveReq), .cpu_we(fiveWe), .cpu_addr(fiveAddr), .cpu_din(fiveDin),
      .cpu_dout(fiveDout), .cpu_ack(fiveCpuAck),
      .dma_req(1'b0), .dma_we(1'b0), .dma_addr(18'h0), .dma_din(8'h0),
      .dma_dout(fiveDmaDout), .dma_ack(fiveDmaAck),
      .mem_addr(fiveMemAddr), .mem_wdata(fiveMemWdata), .mem_rdata(fiveRdata),
      .mem_ce_n(fiveCeN), .mem_oe_n(fiveOeN), .mem_we_n(fiveWeN), .busy(fiveBusy)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock step; everything is sampled 1ns after the rising edge and the strobe monitors accumulate here.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (memWeN === 1'b0) weLow++;
      if (memOeN === 1'b0) oeLow++;
      if (cpuAck === 1'b1) cpuAcks++;
      if (dmaAck === 1'b1) dmaAcks++;
      if (fiveOeN === 1'b0) oeLow5++;
   endtask

   task automatic startCycle();
      cyc = 0;
      weLow = 0;
      oeLow = 0;
      cpuAcks = 0;
      dmaAcks = 0;
      oeLow5 = 0;
   endtask

   task automatic applyStimulus(input int port, input logic req, input logic we,
                                input logic [17:0] addr, input logic [7:0] din);
      if (port == 0) begin
         cpuReq = req; cpuWe = we; cpuAddr = addr; cpuDin = din;
      end else if (port == 1) begin
         dmaReq = req; dmaWe = we; dmaAddr = addr; dmaDin = din;
      end else begin
         fiveReq = req; fiveWe = we; fiveAddr = addr; fiveDin = din;
      end
   endtask

   // Ticks until the selected ack is seen or the budget runs out; ackCyc stays -1 on timeout.
   task automatic waitAck(input int which, input int limit);
      ackCyc = -1;
      for (int i = 0; i < limit; i++) begin
         tick();
         if ((which == 0 && cpuAck === 1'b1) || (which == 1 && dmaAck === 1'b1) ||
             (which == 2 && fiveCpuAck === 1'b1)) begin
            ackCyc = cyc;
            break;
         end
      end
   endtask

   initial begin
      reset_in = 1'b1;
      applyStimulus(0, 1'b0, 1'b0, 18'h0, 8'h0);
      applyStimulus(1, 1'b0, 1'b0, 18'h0, 8'h0);
      applyStimulus(2, 1'b0, 1'b0, 18'h0, 8'h0);
      memRdata = 8'h00;
      fiveRdata = 8'h00;
      startCycle();
      tick();
      tick();
      checkOutput("rst_ce_n", 32'(memCeN), 32'd1);
      checkOutput("rst_oe_n", 32'(memOeN), 32'd1);
      checkOutput("rst_we_n", 32'(memWeN), 32'd1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_addr", 32'(memAddr), 32'h0);
      checkOutput("rst_wdata", 32'(memWdata), 32'h0);
      checkOutput("rst_acks", 32'({cpuAck, dmaAck}), 32'd0);
      checkOutput("rst_douts", 32'({cpuDout, dmaDout}), 32'h0);
      checkOutput("rst5_ce_n", 32'(fiveCeN), 32'd1);
      reset_in = 1'b0;
      tick();

      // CPU write; inputs are scrambled after the latch to prove the access uses captured values.
      startCycle();
      applyStimulus(0, 1'b1, 1'b1, 18'h2ABCD, 8'h5A);
      tick();
      checkOutput("wr_setup_busy", 32'(busy), 32'd1);
      checkOutput("wr_setup_ce_n", 32'(memCeN), 32'd0);
      checkOutput("wr_setup_we_n", 32'(memWeN), 32'd1);
      checkOutput("wr_setup_addr", 32'(memAddr), 32'h2ABCD);
      cpuAddr = 18'h00000;
      cpuDin = 8'hFF;
      waitAck(0, 8);
      checkOutput("wr_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("wr_we_low_cycles", 32'(weLow), 32'd2);
      checkOutput("wr_oe_low_cycles", 32'(oeLow), 32'd0);
      checkOutput("wr_done_we_n", 32'(memWeN), 32'd1);
      checkOutput("wr_done_ce_n", 32'(memCeN), 32'd0);
      checkOutput("wr_done_addr", 32'(memAddr), 32'h2ABCD);
      checkOutput("wr_done_wdata", 32'(memWdata), 32'h5A);
      cpuReq = 1'b0;
      tick();
      checkOutput("wr_ack_pulse", 32'(cpuAck), 32'd0);
      checkOutput("wr_idle_busy", 32'(busy), 32'd0);

      // CPU read back.
      startCycle();
      applyStimulus(0, 1'b1, 1'b0, 18'h2ABCD, 8'h00);
      memRdata = 8'h5A;
      waitAck(0, 8);
      checkOutput("rd_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("rd_dout", 32'(cpuDout), 32'h5A);
      checkOutput("rd_we_low_cycles", 32'(weLow), 32'd0);
      checkOutput("rd_oe_low_cycles", 32'(oeLow), 32'd3);
      cpuReq = 1'b0;
      tick();

      // DMA read raised during a CPU write strobe waits for the next IDLE.
      startCycle();
      applyStimulus(0, 1'b1, 1'b1, 18'h00100, 8'h11);
      tick();
      tick();
      applyStimulus(1, 1'b1, 1'b0, 18'h3FFFF, 8'h00);
      memRdata = 8'hC3;
      waitAck(0, 8);
      checkOutput("busy_cpu_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("busy_no_dma_ack_yet", 32'(dmaAcks), 32'd0);
      cpuReq = 1'b0;
      cyc = 0;
      waitAck(1, 10);
      checkOutput("busy_dma_ack_gap", 32'(ackCyc), 32'd5);
      checkOutput("busy_dma_dout", 32'(dmaDout), 32'hC3);
      checkOutput("busy_cpu_dout_kept", 32'(cpuDout), 32'h5A);
      dmaReq = 1'b0;
      tick();

      // Simultaneous requests: first pair goes to the CPU in every build.
      startCycle();
      applyStimulus(0, 1'b1, 1'b0, 18'h00011, 8'h00);
      applyStimulus(1, 1'b1, 1'b0, 18'h00022, 8'h00);
      memRdata = 8'h77;
      tick();
      checkOutput("tie1_grant_addr", 32'(memAddr), 32'h00011);
      dmaReq = 1'b0;
      waitAck(0, 8);
      checkOutput("tie1_cpu_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("tie1_cpu_dout", 32'(cpuDout), 32'h77);
      checkOutput("tie1_dma_dout_kept", 32'(dmaDout), 32'hC3);
      cpuReq = 1'b0;
      tick();

      // Second simultaneous pair: round-robin hands it to DMA, fixed priority keeps the CPU.
      startCycle();
      applyStimulus(0, 1'b1, 1'b0, 18'h00033, 8'h00);
      applyStimulus(1, 1'b1, 1'b0, 18'h00044, 8'h00);
      memRdata = 8'h99;
      tick();
`ifdef RAMCARD_ARB_RR_EN
      checkOutput("tie2_grant_addr", 32'(memAddr), 32'h00044);
      cpuReq = 1'b0;
      waitAck(1, 8);
      checkOutput("tie2_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("tie2_dma_dout", 32'(dmaDout), 32'h99);
      checkOutput("tie2_cpu_dout_kept", 32'(cpuDout), 32'h77);
      dmaReq = 1'b0;
`else
      checkOutput("tie2_grant_addr", 32'(memAddr), 32'h00033);
      dmaReq = 1'b0;
      waitAck(0, 8);
      checkOutput("tie2_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("tie2_cpu_dout", 32'(cpuDout), 32'h99);
      checkOutput("tie2_dma_dout_kept", 32'(dmaDout), 32'hC3);
      cpuReq = 1'b0;
`endif
      tick();

      // Held request: back-to-back accesses, acks spaced WAIT_CYCLES+3 apart.
      startCycle();
      applyStimulus(0, 1'b1, 1'b1, 18'h00400, 8'h3C);
      waitAck(0, 8);
      checkOutput("held_first_ack", 32'(ackCyc), 32'd4);
      waitAck(0, 8);
      checkOutput("held_second_ack", 32'(ackCyc), 32'd9);
      cpuReq = 1'b0;
      repeat (3) tick();
      checkOutput("held_ack_count", 32'(cpuAcks), 32'd2);
      checkOutput("held_we_low_cycles", 32'(weLow), 32'd4);
      checkOutput("held_idle_busy", 32'(busy), 32'd0);

      // Reset during a write strobe aborts the access without an ack.
      startCycle();
      applyStimulus(0, 1'b1, 1'b1, 18'h00055, 8'hAA);
      tick();
      tick();
      checkOutput("abort_strobe_we_n", 32'(memWeN), 32'd0);
      reset_in = 1'b1;
      tick();
      checkOutput("abort_ce_n", 32'(memCeN), 32'd1);
      checkOutput("abort_we_n", 32'(memWeN), 32'd1);
      checkOutput("abort_oe_n", 32'(memOeN), 32'd1);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      reset_in = 1'b0;
      cpuReq = 1'b0;
      repeat (5) tick();
      checkOutput("abort_no_ack", 32'(cpuAcks), 32'd0);
      checkOutput("abort_dout_cleared", 32'(cpuDout), 32'h00);
      startCycle();
      applyStimulus(0, 1'b1, 1'b0, 18'h00055, 8'h00);
      memRdata = 8'h9E;
      waitAck(0, 8);
      checkOutput("after_abort_ack_cycle", 32'(ackCyc), 32'd4);
      checkOutput("after_abort_dout", 32'(cpuDout), 32'h9E);
      cpuReq = 1'b0;
      tick();

      // WAIT_CYCLES=5 instance: longer strobe and latency.
      startCycle();
      applyStimulus(2, 1'b1, 1'b0, 18'h00123, 8'h00);
      fiveRdata = 8'hA7;
      waitAck(2, 12);
      checkOutput("w5_ack_cycle", 32'(ackCyc), 32'd7);
      checkOutput("w5_oe_low_cycles", 32'(oeLow5), 32'd6);
      checkOutput("w5_dout", 32'(fiveDout), 32'hA7);
      checkOutput("w5_addr", 32'(fiveMemAddr), 32'h00123);
      fiveReq = 1'b0;
      tick();
      checkOutput("w5_idle_busy", 32'(fiveBusy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
